// File: rtl/array_ctrl_pkg.sv
// Shared constants and op encoding for the single-port array request controller.
// The controller, its response buffer and the bench all take their widths from here.
package array_ctrl_pkg;

  localparam int ADDR_W       = 3;
  localparam int DATA_W       = 64;
  localparam int DEPTH        = 2 ** ADDR_W;
  localparam int RESP_DEPTH   = 2;
  localparam int CREDIT_LIMIT = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_e;

endpackage

// File: rtl/array_resp_buf.sv
// Two-entry in-order valid/ready FIFO that holds array read data until the consumer takes it.
// A push and a pop in the same cycle are allowed even when the buffer is full.
module array_resp_buf
  import array_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_reg [RESP_DEPTH];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic [1:0]        count_next;
  logic              do_push;
  logic              do_pop;

  assign full     = (count_reg == 2'(RESP_DEPTH));
  assign empty    = (count_reg == 2'd0);
  assign count    = count_reg;
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_reg[rd_ptr_reg];

  // Entry storage carries no reset; validity is tracked by count_reg alone.
  generate
    for (genvar gi = 0; gi < RESP_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // The upstream read credit must never let a push land on a full, non-draining buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (srst) !(push && full && !pop));

endmodule

// File: rtl/array_1p_req_ctrl.sv
// Arbitrates independent write and read request channels onto the array's single RW0 port,
// tracks the one-cycle read latency and buffers read data behind a valid/ready response port.
module array_1p_req_ctrl
  import array_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  op_e        op;
  logic       inflight_reg;
  logic       inflight_next;
  logic       prio_rd_reg;
  logic       prio_rd_next;
  logic [1:0] buf_count;
  logic       buf_full;
  logic       buf_empty;
  logic       resp_fire;
  logic [2:0] occupancy;
  logic       read_ok;

  assign resp_fire = resp_valid & resp_ready;
  assign occupancy = {2'b00, inflight_reg} + {1'b0, buf_count};
  // Counting a same-cycle pop as freed space keeps one read per cycle flowing when
  // the consumer is always ready; this is the intended resp_ready -> r_ready path.
  assign read_ok   = (occupancy - {2'b00, resp_fire}) < 3'(CREDIT_LIMIT);

  always_comb begin
    op           = OP_IDLE;
    prio_rd_next = prio_rd_reg;
    if (!reset) begin
      if (w_valid && r_valid && read_ok) begin
        op           = prio_rd_reg ? OP_RD : OP_WR;
        prio_rd_next = ~prio_rd_reg;
      end else if (w_valid) begin
        op = OP_WR;
      end else if (r_valid && read_ok) begin
        op = OP_RD;
      end
    end
  end

  assign w_ready       = (op == OP_WR);
  assign r_ready       = (op == OP_RD);
  assign sram_en       = (op != OP_IDLE);
  assign sram_wmode    = (op == OP_WR);
  assign sram_addr     = (op == OP_WR) ? w_addr : ((op == OP_RD) ? r_addr : '0);
  assign sram_wdata    = (op == OP_WR) ? w_data : '0;
  assign inflight_next = (op == OP_RD);

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_reg <= 1'b0;
      prio_rd_reg  <= 1'b1;
    end else begin
      inflight_reg <= inflight_next;
      prio_rd_reg  <= prio_rd_next;
    end
  end

  // Array data is valid the cycle after a read grant, which is exactly when inflight_reg is set.
  array_resp_buf u_resp_buf (
    .clk       (clock),
    .srst      (reset),
    .push      (inflight_reg),
    .push_data (sram_rdata),
    .pop       (resp_fire),
    .pop_data  (resp_data),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign resp_valid = ~buf_empty;

endmodule

// File: tb/tb_array_1p_req_ctrl.sv
// Directed self-checking bench for array_1p_req_ctrl with a behavioural 8x64 single-port array
// (registered read, holds last read data) attached to the sram_* port.
module tb_array_1p_req_ctrl;
  import array_ctrl_pkg::*;

  logic              clock;
  logic              reset;
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic [DATA_W-1:0] mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  array_1p_req_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Array model: registered read, output holds the last read value.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    sram_rdata = '0;
  end
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  initial begin
    reset      = 1'b1;
    w_valid    = 1'b1;
    r_valid    = 1'b1;
    w_addr     = '0;
    w_data     = '0;
    r_addr     = '0;
    resp_ready = 1'b0;

    // Reset: no grants, no array traffic, no response.
    repeat (2) @(negedge clock);
    #1;
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_r_ready", r_ready, 1'b0);
    check("rst_sram_en", sram_en, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);

    // Contended requests alternate R,W,R,W,R,W starting with read.
    @(negedge clock);
    reset      = 1'b0;
    w_valid    = 1'b1;
    w_addr     = 3'd6;
    w_data     = 64'h66;
    r_valid    = 1'b1;
    r_addr     = 3'd7;
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("alt_r_ready_%0d", k), r_ready, (k % 2 == 0));
      check($sformatf("alt_w_ready_%0d", k), w_ready, (k % 2 == 1));
      check($sformatf("alt_sram_en_%0d", k), sram_en, 1'b1);
      @(negedge clock);
    end
    w_valid = 1'b0;
    r_valid = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("alt_drained", resp_valid, 1'b0);

    // Write then read of the same address one cycle later returns the new data.
    @(negedge clock);
    w_valid = 1'b1;
    w_addr  = 3'd3;
    w_data  = 64'hDEAD_BEEF_0000_0003;
    #1;
    check("t1_w_ready", w_ready, 1'b1);
    check("t1_wmode", sram_wmode, 1'b1);
    check("t1_wdata", sram_wdata, 64'hDEAD_BEEF_0000_0003);
    @(negedge clock);
    w_valid = 1'b0;
    r_valid = 1'b1;
    r_addr  = 3'd3;
    #1;
    check("t1_r_ready", r_ready, 1'b1);
    check("t1_rd_wmode", sram_wmode, 1'b0);
    check("t1_rd_addr", sram_addr, 3'd3);
    check("t1_rd_wdata", sram_wdata, 64'h0);
    @(negedge clock);
    r_valid = 1'b0;
    #1;
    check("t1_resp_early", resp_valid, 1'b0);
    @(negedge clock);
    #1;
    check("t1_resp_valid", resp_valid, 1'b1);
    check("t1_resp_data", resp_data, 64'hDEAD_BEEF_0000_0003);
    @(negedge clock);
    #1;
    check("t1_resp_gone", resp_valid, 1'b0);

    // Preload addr i with 0x100+i.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      w_valid = 1'b1;
      w_addr  = 3'(i);
      w_data  = 64'h100 + 64'(i);
      #1;
      check($sformatf("pre_w_ready_%0d", i), w_ready, 1'b1);
    end
    @(negedge clock);
    w_valid = 1'b0;

    // Backpressure: only two reads accepted while responses are not taken.
    resp_ready = 1'b0;
    r_valid    = 1'b1;
    r_addr     = 3'd0;
    #1;
    check("bp_r_ready_0", r_ready, 1'b1);
    @(negedge clock);
    r_addr = 3'd1;
    #1;
    check("bp_r_ready_1", r_ready, 1'b1);
    @(negedge clock);
    r_addr = 3'd2;
    #1;
    check("bp_r_stall_a", r_ready, 1'b0);
    @(negedge clock);
    #1;
    check("bp_r_stall_b", r_ready, 1'b0);
    check("bp_hold_valid", resp_valid, 1'b1);
    check("bp_hold_data", resp_data, 64'h100);
    @(negedge clock);
    resp_ready = 1'b1;
    #1;
    check("bp_pop0", resp_data, 64'h100);
    check("bp_r_ready_2", r_ready, 1'b1);
    @(negedge clock);
    r_addr = 3'd3;
    #1;
    check("bp_pop1", resp_data, 64'h101);
    check("bp_r_ready_3", r_ready, 1'b1);
    @(negedge clock);
    r_valid = 1'b0;
    #1;
    check("bp_pop2_valid", resp_valid, 1'b1);
    check("bp_pop2", resp_data, 64'h102);
    @(negedge clock);
    #1;
    check("bp_pop3_valid", resp_valid, 1'b1);
    check("bp_pop3", resp_data, 64'h103);
    @(negedge clock);
    #1;
    check("bp_empty", resp_valid, 1'b0);

    // Streaming: 8 reads back-to-back, responses on consecutive cycles from grant+2.
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      r_valid = (k < 8);
      r_addr  = 3'(k);
      #1;
      if (k < 8) check($sformatf("st_r_ready_%0d", k), r_ready, 1'b1);
      if (k >= 2) begin
        check($sformatf("st_valid_%0d", k), resp_valid, 1'b1);
        check($sformatf("st_data_%0d", k), resp_data, 64'h100 + 64'(k - 2));
      end
    end
    @(negedge clock);
    r_valid = 1'b0;
    #1;
    check("st_empty", resp_valid, 1'b0);

    // Reset while a read is in flight drops it; no write is issued during reset.
    @(negedge clock);
    r_valid = 1'b1;
    r_addr  = 3'd5;
    #1;
    check("rr_r_ready", r_ready, 1'b1);
    @(negedge clock);
    r_valid = 1'b0;
    reset   = 1'b1;
    w_valid = 1'b1;
    w_addr  = 3'd5;
    w_data  = 64'hBAD;
    #1;
    check("rr_w_ready", w_ready, 1'b0);
    check("rr_sram_en", sram_en, 1'b0);
    @(negedge clock);
    reset   = 1'b0;
    w_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("rr_no_resp_%0d", k), resp_valid, 1'b0);
      @(negedge clock);
    end

    // Read granted before a same-address write returns the old data.
    w_valid = 1'b1;
    w_addr  = 3'd4;
    w_data  = 64'h2;
    #1;
    check("hz_w0_ready", w_ready, 1'b1);
    @(negedge clock);
    w_valid = 1'b0;
    r_valid = 1'b1;
    r_addr  = 3'd4;
    #1;
    check("hz_r_ready", r_ready, 1'b1);
    @(negedge clock);
    r_valid = 1'b0;
    w_valid = 1'b1;
    w_data  = 64'h1;
    #1;
    check("hz_w1_ready", w_ready, 1'b1);
    @(negedge clock);
    w_valid = 1'b0;
    #1;
    check("hz_old_valid", resp_valid, 1'b1);
    check("hz_old_data", resp_data, 64'h2);
    @(negedge clock);
    r_valid = 1'b1;
    #1;
    check("hz_r2_ready", r_ready, 1'b1);
    @(negedge clock);
    r_valid = 1'b0;
    @(negedge clock);
    #1;
    check("hz_new_valid", resp_valid, 1'b1);
    check("hz_new_data", resp_data, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
